// File: rtl/mem_bus_responder.sv
`timescale 1ns/1ps
// Main-memory responder: two-beat reads after LATENCY cycles and two-beat initiator-driven
// writes on a shared tristate bus. Optional out-of-range checking via MEM_RESP_ERR_EN.
module mem_bus_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_req,
    input  logic        mem_en,
    input  logic        mem_rd_wr,
    inout  wire  [31:0] mem_data,
    inout  wire         mem_data_valid,
`ifdef MEM_RESP_ERR_EN
    output logic        mem_err,
`endif
    output logic        mem_busy
);

    localparam int          WORDS    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  LAT_INIT = 4'(LATENCY - 1);
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD_BEAT0,
        RD_BEAT1,
        WR_BEAT0,
        WR_BEAT1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [3:0]            cnt;
    logic [3:0]            cnt_next;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DEPTH_LOG2-1:0] idx_plus1;
    logic [DEPTH_LOG2-1:0] addr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic                  accept;
    logic                  drive;
    logic                  wr_en;
    logic                  bad;
    logic [31:0]           rd_word;
    logic [31:0]           rd_data;
    logic [31:0]           words [WORDS];
    logic                  unused_addr_bits;

    assign addr_idx  = mem_addr[DEPTH_LOG2+1:2];
    assign idx_plus1 = idx + DEPTH_LOG2'(1);
    assign accept    = (state == IDLE) && mem_req && mem_en;

`ifdef MEM_RESP_ERR_EN
    logic addr_bad;
    assign addr_bad         = |mem_addr[31:DEPTH_LOG2+2];
    assign unused_addr_bits = ^mem_addr[1:0];
`else
    // Upper address bits alias onto the array when range checking is disabled.
    assign bad              = 1'b0;
    assign unused_addr_bits = ^{mem_addr[31:DEPTH_LOG2+2], mem_addr[1:0]};
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (mem_rd_wr) begin
                        cnt_next   = LAT_INIT;
                        state_next = (LATENCY == 1) ? RD_BEAT0 : WAIT;
                    end else begin
                        state_next = WR_BEAT0;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) state_next = RD_BEAT0;
            end
            RD_BEAT0: state_next = RD_BEAT1;
            RD_BEAT1: state_next = IDLE;
            WR_BEAT0: if (mem_data_valid) state_next = WR_BEAT1;
            WR_BEAT1: if (mem_data_valid) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // The array is read one cycle ahead of each beat so the output comes straight from a register.
    always_comb begin
        drive  = (state == RD_BEAT0) || (state == RD_BEAT1);
        wr_en  = reset && !bad && mem_data_valid &&
                 ((state == WR_BEAT0) || (state == WR_BEAT1));
        wr_idx = (state == WR_BEAT1) ? idx_plus1 : idx;
        rd_idx = idx;
        case (state)
            IDLE:     rd_idx = addr_idx;
            RD_BEAT0: rd_idx = idx_plus1;
            default:  rd_idx = idx;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            mem_busy <= 1'b0;
`ifdef MEM_RESP_ERR_EN
            mem_err  <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            mem_busy <= (state_next != IDLE);
`ifdef MEM_RESP_ERR_EN
            mem_err  <= accept && addr_bad;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx <= addr_idx;
`ifdef MEM_RESP_ERR_EN
            bad <= addr_bad;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) words[wr_idx] <= mem_data;
        rd_word <= words[rd_idx];
    end

    assign rd_data        = bad ? ERR_WORD : rd_word;
    assign mem_data       = drive ? rd_data : {32{1'bz}};
    assign mem_data_valid = drive ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_mem_bus_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_bus_responder: directed reads/writes queue expected beats,
// a negedge monitor pops and compares every beat the responder drives.
module tb_mem_bus_responder;

    localparam int LAT = 4;

    typedef struct {
        logic [31:0] data;
        int          at;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_en;
    logic        mem_rd_wr;
    wire  [31:0] mem_data;
    wire         mem_data_valid;
    logic        mem_busy;
`ifdef MEM_RESP_ERR_EN
    logic        mem_err;
`endif

    logic [31:0] drv_data;
    logic        drv_data_en;
    logic        drv_vld;
    logic        drv_vld_en;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];

    assign mem_data       = drv_data_en ? drv_data : {32{1'bz}};
    assign mem_data_valid = drv_vld_en ? drv_vld : 1'bz;

    mem_bus_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_req        (mem_req),
        .mem_en         (mem_en),
        .mem_rd_wr      (mem_rd_wr),
        .mem_data       (mem_data),
        .mem_data_valid (mem_data_valid),
`ifdef MEM_RESP_ERR_EN
        .mem_err        (mem_err),
`endif
        .mem_busy       (mem_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release check: valid must not read as 1, and a tb-driven zero must pass through untouched.
    task automatic check_released(input string tag);
        check({tag, "_vld"}, 32'(mem_data_valid === 1'b1), 32'd0);
        drv_data    = 32'h0;
        drv_data_en = 1'b1;
        #1;
        check({tag, "_data"}, mem_data, 32'h0);
        drv_data_en = 1'b0;
    endtask

    task automatic request(input logic [31:0] addr, input logic rd, output int acc);
        mem_addr  = addr;
        mem_rd_wr = rd;
        mem_req   = 1'b1;
        mem_en    = 1'b1;
        tick();
        acc       = cyc;
        mem_req   = 1'b0;
        mem_en    = 1'b0;
    endtask

    task automatic expect_beats(input int acc, input logic [31:0] d0, input logic [31:0] d1);
        exp_q.push_back('{d0, acc + LAT - 1});
        exp_q.push_back('{d1, acc + LAT});
    endtask

    task automatic read_pair(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1);
        int acc;
        request(addr, 1'b1, acc);
        expect_beats(acc, d0, d1);
        for (int k = 0; k < LAT + 1; k++) begin
            check("rd_busy", 32'(mem_busy), 32'd1);
            tick();
        end
        check("rd_done_busy", 32'(mem_busy), 32'd0);
        check_released("rd_done");
    endtask

    task automatic write_pair(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                              input int gap);
        int acc_unused;
        request(addr, 1'b0, acc_unused);
        check("wr_acc_busy", 32'(mem_busy), 32'd1);
        drv_vld_en  = 1'b1;
        drv_data_en = 1'b1;
        drv_vld     = 1'b1;
        drv_data    = d0;
        tick();
        check("wr_beat0_busy", 32'(mem_busy), 32'd1);
        for (int k = 0; k < gap; k++) begin
            drv_vld  = 1'b0;
            drv_data = 32'h0BAD_0BAD;
            tick();
            check("wr_gap_busy", 32'(mem_busy), 32'd1);
        end
        drv_vld  = 1'b1;
        drv_data = d1;
        tick();
        drv_vld_en  = 1'b0;
        drv_data_en = 1'b0;
        drv_vld     = 1'b0;
        check("wr_done_busy", 32'(mem_busy), 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        beat_t b;
        if (!drv_vld_en && mem_data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %h at cycle %0d, required no beat", mem_data, cyc);
            end else begin
                b = exp_q.pop_front();
                check("beat_data", mem_data, b.data);
                check("beat_cycle", 32'(cyc), 32'(b.at));
            end
        end
    end

    initial begin
        int a;
        reset       = 1'b0;
        mem_addr    = 32'h0;
        mem_req     = 1'b0;
        mem_en      = 1'b0;
        mem_rd_wr   = 1'b0;
        drv_data    = 32'h0;
        drv_data_en = 1'b0;
        drv_vld     = 1'b0;
        drv_vld_en  = 1'b0;

        repeat (3) tick();
        check("rst_busy", 32'(mem_busy), 32'd0);
        check_released("rst");
`ifdef MEM_RESP_ERR_EN
        check("rst_err", 32'(mem_err), 32'd0);
`endif
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("idle_busy", 32'(mem_busy), 32'd0);
            check_released("idle");
        end

        write_pair(32'h0000_0100, 32'h1111_1111, 32'h2222_2222, 0);
        read_pair(32'h0000_0100, 32'h1111_1111, 32'h2222_2222);

        // Valid pattern 1,0,0,1: the garbage during the gap must never land in the array.
        write_pair(32'h0000_0200, 32'hA5A5_0001, 32'hA5A5_0002, 2);
        read_pair(32'h0000_0200, 32'hA5A5_0001, 32'hA5A5_0002);

        write_pair(32'h0000_0000, 32'h5555_5555, 32'h6666_6666, 0);
        write_pair(32'h0000_0FFC, 32'h3333_3333, 32'h4444_4444, 0);
        read_pair(32'h0000_0000, 32'h4444_4444, 32'h6666_6666);
        read_pair(32'h0000_0FFC, 32'h3333_3333, 32'h4444_4444);

        mem_addr  = 32'h0000_0100;
        mem_rd_wr = 1'b1;
        mem_req   = 1'b1;
        mem_en    = 1'b0;
        tick();
        mem_req = 1'b0;
        check("no_en_busy", 32'(mem_busy), 32'd0);
        repeat (8) tick();

        request(32'h0000_0100, 1'b1, a);
        expect_beats(a, 32'h1111_1111, 32'h2222_2222);
        mem_addr  = 32'h0000_0200;
        mem_rd_wr = 1'b1;
        mem_req   = 1'b1;
        mem_en    = 1'b1;
        tick();
        mem_req = 1'b0;
        mem_en  = 1'b0;
        repeat (4) tick();
        check("coll_busy", 32'(mem_busy), 32'd0);
        repeat (8) tick();

        request(32'h0000_0200, 1'b1, a);
        exp_q.push_back('{32'hA5A5_0001, a + LAT - 1});
        while (cyc < a + LAT - 1) tick();
        reset = 1'b0;
        tick();
        check("rst_rd_busy", 32'(mem_busy), 32'd0);
        check_released("rst_rd");
        reset = 1'b1;
        tick();

        write_pair(32'h0000_0300, 32'h9999_9999, 32'hAAAA_AAAA, 0);
        request(32'h0000_0300, 1'b0, a);
        drv_vld_en  = 1'b1;
        drv_data_en = 1'b1;
        drv_vld     = 1'b1;
        drv_data    = 32'h7777_7777;
        tick();
        drv_vld = 1'b0;
        reset   = 1'b0;
        tick();
        drv_vld_en  = 1'b0;
        drv_data_en = 1'b0;
        check("rst_wr_busy", 32'(mem_busy), 32'd0);
        reset = 1'b1;
        tick();
        read_pair(32'h0000_0300, 32'h7777_7777, 32'hAAAA_AAAA);
        read_pair(32'h0000_0100, 32'h1111_1111, 32'h2222_2222);

`ifdef MEM_RESP_ERR_EN
        request(32'h1000_0000, 1'b1, a);
        check("err_pulse", 32'(mem_err), 32'd1);
        expect_beats(a, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        tick();
        check("err_clear", 32'(mem_err), 32'd0);
        repeat (LAT) tick();
        check("err_rd_busy", 32'(mem_busy), 32'd0);

        write_pair(32'h1000_0000, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        request(32'h0000_0000, 1'b1, a);
        check("ok_no_err", 32'(mem_err), 32'd0);
        expect_beats(a, 32'h4444_4444, 32'h6666_6666);
        repeat (LAT + 1) tick();
        check("ok_rd_busy", 32'(mem_busy), 32'd0);
`endif

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
